// File: rtl/fp16_tpu_pkg.sv
// Shared types and constants for the FP16 PE-row drain controller.
//   FP16_WIDTH / FP16_ZERO : FP16 word width and positive-zero encoding
//   drain_state_t          : tile sequencer state encoding
//   fp16_is_neg()          : sign-bit test used by the optional ReLU on readout
package fp16_tpu_pkg;

  localparam int unsigned FP16_WIDTH = 16;
  localparam logic [FP16_WIDTH-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCUM   = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4
  } drain_state_t;

  // Sign bit alone decides: covers -0, negative Inf and negative NaN too.
  function automatic logic fp16_is_neg(input logic [FP16_WIDTH-1:0] w);
    return w[FP16_WIDTH-1];
  endfunction

endpackage

// File: rtl/fp16_drain_shadow_bank.sv
// Shadow capture registers for one PE row plus the column read mux.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears all words)
//   load       : capture every column of load_data this cycle
//   load_data  : NUM_COLS packed FP16 words, column c at [16c+15:16c]
//   sel        : column index for rd_data
//   rd_data    : shadow word of column sel
module fp16_drain_shadow_bank
  import fp16_tpu_pkg::*;
#(
  parameter  int unsigned NUM_COLS = 8,
  localparam int unsigned COL_W    = $clog2(NUM_COLS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [NUM_COLS*FP16_WIDTH-1:0] load_data,
  input  logic [COL_W-1:0]               sel,
  output logic [FP16_WIDTH-1:0]          rd_data
);

  logic [FP16_WIDTH-1:0] shadow [NUM_COLS];

  // Capture the whole row in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(NUM_COLS); c++) shadow[c] <= FP16_ZERO;
    end else if (load) begin
      for (int c = 0; c < int'(NUM_COLS); c++) shadow[c] <= load_data[c*FP16_WIDTH +: FP16_WIDTH];
    end
  end

  assign rd_data = shadow[sel];

endmodule

// File: rtl/fp16_acc_drain_ctrl.sv
// Tile sequencer and result reader for one row of FP16 MAC PEs.
// Runs a K_DEPTH accumulation, flushes the PEs, captures all NUM_COLS results
// and streams them one word per valid/ready transfer.
// Optional feature: define FP16_DRAIN_RELU_EN to zero any word whose sign bit is set.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   start                         : tile request, honoured only when idle
//   mac_enable, acc_clear         : PE row controls
//   acc_in                        : PE acc_out bus, column c at [16c+15:16c]
//   out_valid/out_ready           : readout handshake
//   out_data, out_col, out_last   : readout word, its column, last-column flag
//   busy                          : high whenever not idle
//   tile_done                     : one-cycle pulse after the last transfer
module fp16_acc_drain_ctrl
  import fp16_tpu_pkg::*;
#(
  parameter  int unsigned NUM_COLS = 8,
  parameter  int unsigned K_DEPTH  = 16,
  localparam int unsigned CNT_W    = $clog2(K_DEPTH + 1),
  localparam int unsigned COL_W    = $clog2(NUM_COLS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           mac_enable,
  output logic                           acc_clear,
  input  logic [NUM_COLS*FP16_WIDTH-1:0] acc_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [FP16_WIDTH-1:0]          out_data,
  output logic [COL_W-1:0]               out_col,
  output logic                           out_last,
  output logic                           busy,
  output logic                           tile_done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_DEPTH - 1);

  drain_state_t          state, next_state;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [COL_W-1:0]      idx_d;
  logic [FP16_WIDTH-1:0] rd_data, out_data_d;
  logic                  xfer;
  logic                  mac_enable_d, acc_clear_d, out_valid_d, out_last_d;
  logic                  busy_d, tile_done_d;

  function automatic logic [FP16_WIDTH-1:0] drain_word(input logic [FP16_WIDTH-1:0] w);
`ifdef FP16_DRAIN_RELU_EN
    return fp16_is_neg(w) ? FP16_ZERO : w;
`else
    return w;
`endif
  endfunction

  assign xfer = out_valid & out_ready;

  fp16_drain_shadow_bank #(.NUM_COLS(NUM_COLS)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ST_CAPTURE),
    .load_data (acc_in),
    .sel       (idx_d),
    .rd_data   (rd_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (start) next_state = ST_ACCUM;
      ST_ACCUM:   if (cnt == LAST_CNT) next_state = ST_FLUSH;
      ST_FLUSH:   next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = ST_DRAIN;
      ST_DRAIN:   if (xfer && out_last) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Output decode: values for the coming cycle, registered below.
  // Readout word is fetched one cycle ahead; on the capture edge the shadow
  // regs are not yet loaded, so column 0 comes straight from acc_in.
  always_comb begin
    cnt_d        = cnt;
    idx_d        = out_col;
    out_data_d   = out_data;
    mac_enable_d = (next_state == ST_ACCUM) || (next_state == ST_FLUSH);
    acc_clear_d  = ((state == ST_IDLE) && (next_state == ST_ACCUM)) || (next_state == ST_FLUSH);
    out_valid_d  = (next_state == ST_DRAIN);
    busy_d       = (next_state != ST_IDLE);
    tile_done_d  = xfer && out_last;

    if (state == ST_IDLE)       cnt_d = '0;
    else if (state == ST_ACCUM) cnt_d = cnt + CNT_W'(1);

    if (state == ST_CAPTURE) begin
      idx_d      = '0;
      out_data_d = drain_word(acc_in[FP16_WIDTH-1:0]);
    end else if (xfer) begin
      idx_d      = out_last ? '0 : out_col + COL_W'(1);
      out_data_d = out_last ? FP16_ZERO : drain_word(rd_data);
    end

    out_last_d = (next_state == ST_DRAIN) && (idx_d == LAST_COL);
  end

  // Registered outputs and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      mac_enable <= 1'b0;
      acc_clear  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= FP16_ZERO;
      out_col    <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      tile_done  <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      mac_enable <= mac_enable_d;
      acc_clear  <= acc_clear_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_col    <= idx_d;
      out_last   <= out_last_d;
      busy       <= busy_d;
      tile_done  <= tile_done_d;
    end
  end

endmodule

// File: tb/tb_fp16_acc_drain_ctrl.sv
// Bench for fp16_acc_drain_ctrl (NUM_COLS=4, K_DEPTH=4). Expected readout words
// are queued when a tile starts and checked as transfers happen.
module tb_fp16_acc_drain_ctrl;

  localparam int unsigned NC = 4;
  localparam int unsigned KD = 4;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [NC*16-1:0] acc_in;
  logic          mac_enable, acc_clear, out_valid, out_last, busy, tile_done;
  logic [15:0]   out_data;
  logic [1:0]    out_col;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  col;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fp16_acc_drain_ctrl #(.NUM_COLS(NC), .K_DEPTH(KD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mac_enable (mac_enable),
    .acc_clear  (acc_clear),
    .acc_in     (acc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .tile_done  (tile_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef FP16_DRAIN_RELU_EN
    return w[15] ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the tile's expected words, then hold start for the current cycle.
  task automatic start_tile(input logic [NC*16-1:0] bus);
    exp_t e;
    acc_in = bus;
    for (int c = 0; c < int'(NC); c++) begin
      e.data = exp_word(bus[c*16 +: 16]);
      e.col  = 2'(c);
      e.last = (c == int'(NC) - 1);
      sb.push_back(e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!tile_done && n < 100) begin
      tick();
      n++;
    end
    check("tile_done_seen", 32'(tile_done), 32'd1);
  endtask

  // Transfer monitor and backpressure stability checker.
  logic        hold = 1'b0;
  logic [15:0] h_data;
  logic [1:0]  h_col;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(h_data));
        check("hold_col", 32'(out_col), 32'(h_col));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_word", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("word_data", 32'(out_data), 32'(e.data));
          check("word_col", 32'(out_col), 32'(e.col));
          check("word_last", 32'(out_last), 32'(e.last));
        end
        hold = 1'b0;
      end else if (out_valid) begin
        hold   = 1'b1;
        h_data = out_data;
        h_col  = out_col;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    int n, seen;
    bit bp;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; acc_in = '0;
    tick(); tick();

    // Reset state.
    check("rst_mac_enable", 32'(mac_enable), 32'd0);
    check("rst_acc_clear", 32'(acc_clear), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_col", 32'(out_col), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tile_done", 32'(tile_done), 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: cycle-exact timing of one tile.
    start_tile({16'h4200, 16'hC000, 16'h4000, 16'h3C00});
    for (int i = 1; i <= 11; i++) begin
      check($sformatf("t1_mac_enable_c%0d", i), 32'(mac_enable), 32'(i >= 1 && i <= 5));
      check($sformatf("t1_acc_clear_c%0d", i), 32'(acc_clear), 32'(i == 1 || i == 5));
      check($sformatf("t1_out_valid_c%0d", i), 32'(out_valid), 32'(i >= 7 && i <= 10));
      check($sformatf("t1_out_last_c%0d", i), 32'(out_last), 32'(i == 10));
      check($sformatf("t1_tile_done_c%0d", i), 32'(tile_done), 32'(i == 11));
      check($sformatf("t1_busy_c%0d", i), 32'(busy), 32'(i <= 10));
      if (i == 9) check("t1_col2_data", 32'(out_data), 32'(exp_word(16'hC000)));
      tick();
    end
    check("t1_drained", 32'(sb.size()), 32'd0);

    // Test 2: backpressure while column 1 is presented.
    start_tile({16'h4200, 16'hC000, 16'h4000, 16'h3C00});
    n = 0; bp = 1'b0;
    while (!tile_done && n < 60) begin
      if (!bp && out_valid && out_col == 2'd1) begin
        out_ready = 1'b0;
        repeat (3) begin
          tick();
          check("t2_bp_data", 32'(out_data), 32'h4000);
          check("t2_bp_col", 32'(out_col), 32'd1);
          check("t2_bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        bp = 1'b1;
      end
      tick();
      n++;
    end
    check("t2_done", 32'(tile_done), 32'd1);
    check("t2_bp_seen", 32'(bp), 32'd1);
    check("t2_drained", 32'(sb.size()), 32'd0);

    // Test 4: start pulses in ACCUM and DRAIN are ignored; negative words exercise ReLU.
    start_tile({16'hBC00, 16'h7C00, 16'hFC00, 16'h8000});
    for (int i = 1; i <= 11; i++) begin
      start = (i == 2) || (i == 8);
      check($sformatf("t4_busy_c%0d", i), 32'(busy), 32'(i <= 10));
      check($sformatf("t4_tile_done_c%0d", i), 32'(tile_done), 32'(i == 11));
      tick();
    end
    start = 1'b0;
    repeat (5) begin
      check("t4_no_second_tile", 32'(out_valid | busy), 32'd0);
      tick();
    end
    check("t4_drained", 32'(sb.size()), 32'd0);

    // Test 5: reset mid-drain after two transfers.
    start_tile({16'h1234, 16'h5678, 16'h9ABC, 16'h0DEF});
    seen = 0; n = 0;
    while (seen < 2 && n < 40) begin
      if (out_valid) seen++;
      tick();
      n++;
    end
    check("t5_col_before_rst", 32'(out_col), 32'd2);
    rst = 1'b1;
    tick();
    sb.delete();
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_data", 32'(out_data), 32'd0);
    check("t5_rst_col", 32'(out_col), 32'd0);
    check("t5_rst_last", 32'(out_last), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(tile_done), 32'd0);
    check("t5_rst_mac", 32'(mac_enable), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("t5_idle_after_rst", 32'(out_valid | busy), 32'd0);
    end
    start_tile({16'h3800, 16'hB800, 16'h3400, 16'h0001});
    wait_done(n);
    check("t5_latency", 32'(n), 32'd10);
    check("t5_drained", 32'(sb.size()), 32'd0);

    // Test 6: back-to-back tiles, second start on the tile_done cycle.
    start_tile({16'h4400, 16'h4500, 16'h4600, 16'h4700});
    wait_done(n);
    check("t6_latency1", 32'(n), 32'd10);
    start_tile({16'hC400, 16'h0400, 16'hE000, 16'h2000});
    wait_done(n);
    check("t6_latency2", 32'(n), 32'd10);
    tick();
    check("t6_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
